// File: rtl/sum_pkg.sv
// Shared definitions for the running-sum encode/decode pair (sum_reduce / sum_diff).
package sum_pkg;

    // Default width of sums and increments.
    localparam int COUNT_OF_BITS_DEF = 4;

    // IDLE: no sample seen since reset/restart; RUN: prev holds the last sample.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sum_diff.sv
// sum_diff: recovers per-sample increments from a stream of running sums.
// num = sum - prev (mod 2^N), with first-sample tracking, restart and a wrap flag.
// One-entry output register with valid/ready handshake on both sides.
module sum_diff
    import sum_pkg::*;
#(
    parameter int COUNT_OF_BITS = COUNT_OF_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sum_valid,
    output logic                     sum_ready,
    input  logic [COUNT_OF_BITS-1:0] sum,
    input  logic                     restart,
    output logic                     num_valid,
    input  logic                     num_ready,
    output logic [COUNT_OF_BITS-1:0] num,
    output logic                     first,
    output logic                     wrapped
);

    state_t                   state;
    logic [COUNT_OF_BITS-1:0] prev;
    logic                     accept;
    logic                     from_zero;

    // Output register can take a new result when empty or being drained this cycle.
    assign sum_ready = !num_valid || num_ready;
    assign accept    = sum_valid && sum_ready;

    // Restart wins over RUN: a sample accepted together with restart is differenced against 0.
    assign from_zero = restart || (state == IDLE);

    // State, previous sample and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prev      <= '0;
            num       <= '0;
            first     <= 1'b0;
            wrapped   <= 1'b0;
            num_valid <= 1'b0;
        end else if (accept) begin
            if (from_zero) begin
                num     <= sum;
                first   <= 1'b1;
                wrapped <= 1'b0;
            end else begin
                num     <= sum - prev;
                first   <= 1'b0;
                wrapped <= (sum < prev);
            end
            num_valid <= 1'b1;
            prev      <= sum;
            state     <= RUN;
        end else begin
            // Restart without a sample only rewinds the reference; a pending result stays.
            if (restart) begin
                state <= IDLE;
                prev  <= '0;
            end
            if (num_valid && num_ready)
                num_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sum_diff.sv
// Directed self-checking bench for sum_diff (COUNT_OF_BITS = 4).
module tb_sum_diff;
    import sum_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sum_valid;
    logic         sum_ready;
    logic [W-1:0] sum;
    logic         restart;
    logic         num_valid;
    logic         num_ready;
    logic [W-1:0] num;
    logic         first;
    logic         wrapped;

    int errors = 0;
    int checks = 0;

    sum_diff #(.COUNT_OF_BITS(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum       (sum),
        .restart   (restart),
        .num_valid (num_valid),
        .num_ready (num_ready),
        .num       (num),
        .first     (first),
        .wrapped   (wrapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample (optionally with restart) and clock it in.
    task automatic send(input logic [W-1:0] s, input logic r);
        sum_valid = 1'b1;
        sum       = s;
        restart   = r;
        step();
        sum_valid = 1'b0;
        restart   = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] n, input logic f, input logic w);
        chk({tag, ".valid"}, 32'(num_valid), 32'd1);
        chk({tag, ".num"}, 32'(num), 32'(n));
        chk({tag, ".first"}, 32'(first), 32'(f));
        chk({tag, ".wrap"}, 32'(wrapped), 32'(w));
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    initial begin
        logic [W-1:0] acc;
        logic [W-1:0] n;

        rst = 1'b1; sum_valid = 1'b0; sum = '0; restart = 1'b0; num_ready = 1'b1;
        #2;
        chk("rst.valid", 32'(num_valid), 32'd0);
        chk("rst.num", 32'(num), 32'd0);
        chk("rst.first", 32'(first), 32'd0);
        chk("rst.wrap", 32'(wrapped), 32'd0);
        chk("rst.ready", 32'(sum_ready), 32'd1);
        step();
        rst = 1'b0;
        step();

        // Plain stream
        send(4'd1, 1'b0); expect_out("s1", 4'd1, 1'b1, 1'b0);
        send(4'd3, 1'b0); expect_out("s2", 4'd2, 1'b0, 1'b0);
        send(4'd6, 1'b0); expect_out("s3", 4'd3, 1'b0, 1'b0);
        send(4'd6, 1'b0); expect_out("s4", 4'd0, 1'b0, 1'b0);
        step();
        chk("drain.valid", 32'(num_valid), 32'd0);

        // Wrap
        pulse_restart();
        send(4'd14, 1'b0); expect_out("w1", 4'd14, 1'b1, 1'b0);
        send(4'd2, 1'b0);  expect_out("w2", 4'd4, 1'b0, 1'b1);

        // Backpressure
        pulse_restart();
        send(4'd1, 1'b0); expect_out("b1", 4'd1, 1'b1, 1'b0);
        send(4'd3, 1'b0); expect_out("b2", 4'd2, 1'b0, 1'b0);
        num_ready = 1'b0;
        sum_valid = 1'b1;
        sum       = 4'd6;
        #1;
        chk("bp.ready", 32'(sum_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp.hold.num", 32'(num), 32'd2);
            chk("bp.hold.valid", 32'(num_valid), 32'd1);
            chk("bp.hold.ready", 32'(sum_ready), 32'd0);
        end
        num_ready = 1'b1;
        #1;
        chk("bp.release.ready", 32'(sum_ready), 32'd1);
        step();
        sum_valid = 1'b0;
        expect_out("b3", 4'd3, 1'b0, 1'b0);
        step();
        chk("bp.drain.valid", 32'(num_valid), 32'd0);

        // Restart together with an accepted sample (prev is 6 here)
        send(4'd9, 1'b1);  expect_out("r1", 4'd9, 1'b1, 1'b0);
        send(4'd10, 1'b0); expect_out("r2", 4'd1, 1'b0, 1'b0);

        // Restart alone leaves a pending result in place
        num_ready = 1'b0;
        pulse_restart();
        chk("rp.valid", 32'(num_valid), 32'd1);
        chk("rp.num", 32'(num), 32'd1);
        num_ready = 1'b1;
        send(4'd7, 1'b0); expect_out("rp2", 4'd7, 1'b1, 1'b0);

        // Asynchronous reset mid-stream
        pulse_restart();
        send(4'd1, 1'b0);
        send(4'd3, 1'b0); expect_out("m2", 4'd2, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mrst.valid", 32'(num_valid), 32'd0);
        chk("mrst.num", 32'(num), 32'd0);
        rst = 1'b0;
        step();
        send(4'd5, 1'b0); expect_out("m3", 4'd5, 1'b1, 1'b0);

        // Round trip through a software accumulator
        pulse_restart();
        acc = '0;
        for (int i = 0; i < 24; i++) begin
            n   = W'($urandom_range(0, (1 << W) - 1));
            acc = acc + n;
            send(acc, 1'b0);
            chk("rt.num", 32'(num), 32'(n));
            chk("rt.first", 32'(first), (i == 0) ? 32'd1 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sum_diff.md
# sum_diff

Inverse of the `sum_reduce` accumulator: consumes a stream of running sums and recovers the per-cycle increments, `num[k] = sum[k] - sum[k-1]` mod 2^N. Sits on the receive side of any link that transports accumulated values; feeding `sum_reduce` output into this block returns the original `num` sequence. Adds a valid/ready handshake, first-sample tracking, a restart input and a wrap flag.

## Interface
- `COUNT_OF_BITS`, default 4: width of sums and recovered increments.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sum_valid`  in  1  `sum` holds a sample.
- `sum_ready`  out  1  block accepts a sample this cycle.
- `sum`  in  COUNT_OF_BITS  running-sum sample, unsigned.
- `restart`  in  1  single-cycle pulse; next difference is taken against 0.
- `num_valid`  out  1  `num` holds a result.
- `num_ready`  in  1  downstream accepts `num`.
- `num`  out  COUNT_OF_BITS  recovered increment.
- `first`  out  1  `num` is the first result after reset or restart.
- `wrapped`  out  1  `sum < previous sum` (modular wrap occurred).

## Operation
- Accept: `sum_valid && sum_ready` in a cycle.
- Registers: `prev` (COUNT_OF_BITS), state, output register (`num`, `first`, `wrapped`, `num_valid`).
- States: IDLE (no sample since reset/restart), RUN.
  - IDLE + accept -> RUN; result `num = sum - 0 = sum`, `first=1`, `wrapped=0`.
  - RUN + accept -> RUN; `num = sum - prev` mod 2^N, `first=0`, `wrapped = (sum < prev)`.
  - On every accept `prev <= sum`.
- `restart` (any state): state -> IDLE, `prev <= 0`. A sample accepted in the same cycle is treated as IDLE (restart has priority): `num = sum`, `first=1`, state ends RUN, `prev <= sum`.
- `restart` does not flush a pending output; `num_valid` result already in the output register stays until consumed.
- Arithmetic: plain COUNT_OF_BITS subtraction, borrow discarded; borrow is reported as `wrapped`.
- Equal consecutive sums give `num=0`, `wrapped=0`.

## Timing
- Reset values: `num=0`, `num_valid=0`, `first=0`, `wrapped=0`, `prev=0`, state IDLE. `sum_ready` is 1 during and after reset (output register empty).
- `sum_ready = !num_valid || num_ready` (combinational from `num_ready`; no combinational path from `sum_valid` to `sum_ready`).
- Latency: result appears in the cycle after acceptance; throughput one sample per cycle with `num_ready` held high.
- Output register loads on accept; `num_valid` clears when `num_valid && num_ready && !accept`.
- While `num_valid && !num_ready`: `num`, `first`, `wrapped` held stable, no accept, `prev` unchanged.
- Reset asserted mid-stream: all state cleared immediately (asynchronous); pending result discarded; next sample after reset release is `first`.

## Structure
- Shared package `sum_pkg`: state typedef (`IDLE`, `RUN`) and the default width constant, shared with `sum_reduce`.
- Single module; no sub-module. Output register stays inline.

## Test plan
- Stream, `COUNT_OF_BITS=4`, `num_ready=1`: sums 1,3,6,6 on consecutive cycles -> nums 1,2,3,0 one cycle later each; `first` only on the 1; `wrapped` always 0.
- Wrap: sums 14,2 -> nums 14,4; `wrapped=0` then 1.
- Backpressure: sums 1,3 then `num_ready=0` for 3 cycles -> `num=2` held, `sum_ready=0`, sample 6 waits; on release nums 2,3 with no loss or duplication.
- Restart with simultaneous accept: running at prev=6, `restart=1` with sum=9 -> `num=9`, `first=1`; next sum 10 -> `num=1`, `first=0`.
- Reset mid-stream: after sums 1,3, assert `rst` between clock edges -> `num_valid`, `num` drop to 0 immediately; after release sum 5 -> `num=5`, `first=1`.
- Round trip: random `num` into `sum_reduce`, its `sum` into this block -> output sequence equals input sequence.
